// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
// State encoding, master ids and the watchdog counter width helper.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      ABORT,
      DRAIN
   } mb_state_t;

   localparam logic MB_M0 = 1'b0;
   localparam logic MB_M1 = 1'b1;

   localparam int MB_ADDR_W  = 32;
   localparam int MB_DATA_W  = 32;
   localparam int MB_TIMEOUT = 255;

   // Width able to hold 0..t; a disabled watchdog still needs one bit.
   function automatic int mb_cnt_w(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Counts consecutive ack-less granted cycles and flags an expiry.
// Counter saturates; TIMEOUT of 0 never expires.
module mem_bus_watchdog
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT = MB_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic kick,
   output logic expired
);

   localparam int CW = mb_cnt_w(TIMEOUT);
   localparam logic [CW-1:0] CMAX  = '1;
   localparam logic [CW-1:0] LIMIT =
      (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam bit ENABLED = (TIMEOUT > 0);

   logic [CW-1:0] cnt;

   // Clear whenever the bus is not held or memory answers, else count up.
   always_ff @(posedge clk) begin
      if (rst || !run || kick) begin
         cnt <= '0;
      end else if (cnt != CMAX) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = ENABLED && run && !kick && (cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between two masters.
// Grant is held for the whole cyc period; hung cycles are aborted.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = MB_ADDR_W,
   parameter int DATA_W  = MB_DATA_W,
   parameter int TIMEOUT = MB_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_cyc_i,
   input  logic              m1_cyc_i,
   input  logic              m0_we_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m0_adr_i,
   input  logic [ADDR_W-1:0] m1_adr_i,
   input  logic [DATA_W-1:0] m0_dat_i,
   input  logic [DATA_W-1:0] m1_dat_i,
   output logic [DATA_W-1:0] m0_dat_o,
   output logic [DATA_W-1:0] m1_dat_o,
   output logic              m0_ack_o,
   output logic              m1_ack_o,
   output logic              m0_err_o,
   output logic              m1_err_o,
   output logic              cyc_m2s,
   output logic              we_m2s,
   output logic [ADDR_W-1:0] adr_m2s,
   output logic [DATA_W-1:0] dat_m2s,
   input  logic              ack_mem,
   input  logic [DATA_W-1:0] dat_mem
);

   mb_state_t state, state_nx;
   logic      owner, owner_nx;
   logic      last, last_nx;
   logic      own_cyc;
   logic      run;
   logic      expired;
   logic      gnt;
   logic      live;

   assign own_cyc = (owner == MB_M1) ? m1_cyc_i : m0_cyc_i;
   assign gnt     = (state == GRANT);
   assign live    = gnt && own_cyc;
   assign run     = live;

   mem_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .kick    (ack_mem),
      .expired (expired)
   );

   // State, owner and round-robin history registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= MB_M0;
         last  <= MB_M1;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         last  <= last_nx;
      end
   end

   // Arbitration and transaction lifetime transitions.
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      last_nx  = last;
      unique case (state)
         IDLE: begin
            if (m0_cyc_i || m1_cyc_i) begin
               if (m0_cyc_i && m1_cyc_i) begin
                  owner_nx = ~last;
               end else begin
                  owner_nx = m1_cyc_i;
               end
               last_nx  = owner_nx;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            if (!own_cyc) begin
               state_nx = IDLE;
            end else if (expired) begin
               state_nx = ABORT;
            end
         end
         ABORT: state_nx = DRAIN;
         DRAIN: begin
            if (!own_cyc) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Owner-side muxing to memory and return path back to the owner.
   always_comb begin
      cyc_m2s  = live;
      we_m2s   = 1'b0;
      adr_m2s  = '0;
      dat_m2s  = '0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_dat_o = '0;
      m1_dat_o = '0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      if (gnt) begin
         we_m2s  = (owner == MB_M1) ? m1_we_i  : m0_we_i;
         adr_m2s = (owner == MB_M1) ? m1_adr_i : m0_adr_i;
         dat_m2s = (owner == MB_M1) ? m1_dat_i : m0_dat_i;
         if (owner == MB_M1) begin
            m1_ack_o = live && ack_mem;
            m1_dat_o = dat_mem;
         end else begin
            m0_ack_o = live && ack_mem;
            m0_dat_o = dat_mem;
         end
      end
      if (state == ABORT) begin
         m0_err_o = (owner == MB_M0);
         m1_err_o = (owner == MB_M1);
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with TIMEOUT = 8.
// Expected grants and read data flow through scoreboard queues.
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m0_cyc = 1'b0, m1_cyc = 1'b0;
   logic          m0_we = 1'b0, m1_we = 1'b0;
   logic [AW-1:0] m0_adr = '0, m1_adr = '0;
   logic [DW-1:0] m0_wd = '0, m1_wd = '0;
   logic [DW-1:0] m0_rd, m1_rd;
   logic          m0_ack, m1_ack, m0_err, m1_err;
   logic          cyc_m2s, we_m2s;
   logic [AW-1:0] adr_m2s;
   logic [DW-1:0] dat_m2s;
   logic          ack_mem = 1'b0;
   logic [DW-1:0] dat_mem = '0;

   int n_chk = 0;
   int n_fail = 0;

   logic [AW-1:0] grant_q[$];
   logic [DW-1:0] rdat_q[$];
   logic [DW-1:0] exp_v;

   logic [2*DW+AW+DW+DW+5:0] all_out;
   assign all_out = {cyc_m2s, we_m2s, adr_m2s, dat_m2s,
                     m0_ack, m1_ack, m0_err, m1_err, m0_rd, m1_rd};

   mem_bus_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(TO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m0_cyc_i(m0_cyc),
      .m1_cyc_i(m1_cyc),
      .m0_we_i (m0_we),
      .m1_we_i (m1_we),
      .m0_adr_i(m0_adr),
      .m1_adr_i(m1_adr),
      .m0_dat_i(m0_wd),
      .m1_dat_i(m1_wd),
      .m0_dat_o(m0_rd),
      .m1_dat_o(m1_rd),
      .m0_ack_o(m0_ack),
      .m1_ack_o(m1_ack),
      .m0_err_o(m0_err),
      .m1_err_o(m1_err),
      .cyc_m2s (cyc_m2s),
      .we_m2s  (we_m2s),
      .adr_m2s (adr_m2s),
      .dat_m2s (dat_m2s),
      .ack_mem (ack_mem),
      .dat_mem (dat_mem)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic pop_grant(input string nm);
      n_chk++;
      if (grant_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: grant seen, none expected", nm);
      end else begin
         exp_v = grant_q.pop_front();
         if (cyc_m2s !== 1'b1 || adr_m2s !== exp_v) begin
            n_fail++;
            $display("FAIL %s: cyc=%b adr=%h want cyc=1 adr=%h",
                     nm, cyc_m2s, adr_m2s, exp_v);
         end
      end
   endtask

   task automatic pop_rdat(input string nm, input logic [DW-1:0] got);
      n_chk++;
      if (rdat_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: read data seen, none expected", nm);
      end else begin
         exp_v = rdat_q.pop_front();
         if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp_v);
         end
      end
   endtask

   task automatic test_reset();
      step();
      step();
      settle();
      n_chk++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: got %h want 0", all_out);
      end
      rst = 1'b0;
      step();
      m0_cyc = 1'b1;
      m0_adr = 32'h100;
      grant_q.push_back(32'h100);
      settle();
      step();
      ack_mem = 1'b1;
      dat_mem = 32'h11;
      settle();
      pop_grant("reset_pre_grant");
      n_chk++;
      if (m0_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre_ack: got %b want 1", m0_ack);
      end
      step();
      rst = 1'b1;
      settle();
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 1) m1_cyc = 1'b1;
         if (i == 2) begin
            rst = 1'b0;
            ack_mem = 1'b0;
            grant_q.push_back(32'h100);
         end
         settle();
         n_chk++;
         if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_%0d: got %h want 0", i, all_out);
         end
      end
      step();
      settle();
      pop_grant("reset_release_m0");
      n_chk++;
      if (m1_ack !== 1'b0 || m0_err !== 1'b0 || m1_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_side: m1_ack=%b errs=%b%b want 0",
                  m1_ack, m0_err, m1_err);
      end
      step();
      m0_cyc = 1'b0;
      m1_cyc = 1'b0;
      step();
      step();
   endtask

   task automatic test_single_read();
      step();
      m0_cyc = 1'b1;
      m0_we  = 1'b0;
      m0_adr = 32'h40;
      grant_q.push_back(32'h40);
      settle();
      n_chk++;
      if (cyc_m2s !== 1'b0) begin
         n_fail++;
         $display("FAIL read_latency: cyc=%b want 0", cyc_m2s);
      end
      step();
      settle();
      pop_grant("read_grant");
      n_chk++;
      if (m0_ack !== 1'b0 || we_m2s !== 1'b0) begin
         n_fail++;
         $display("FAIL read_pre_ack: ack=%b we=%b want 0 0", m0_ack, we_m2s);
      end
      step();
      ack_mem = 1'b1;
      dat_mem = 32'hDEADBEEF;
      rdat_q.push_back(32'hDEADBEEF);
      settle();
      n_chk++;
      if (m0_ack !== 1'b1 || adr_m2s !== 32'h40) begin
         n_fail++;
         $display("FAIL read_ack: ack=%b adr=%h want 1 40", m0_ack, adr_m2s);
      end
      pop_rdat("read_data", m0_rd);
      n_chk++;
      if (m1_ack !== 1'b0 || m1_rd !== '0 || m1_err !== 1'b0) begin
         n_fail++;
         $display("FAIL read_m1_quiet: ack=%b dat=%h err=%b want 0",
                  m1_ack, m1_rd, m1_err);
      end
      step();
      ack_mem = 1'b0;
      m0_cyc  = 1'b0;
      settle();
      n_chk++;
      if (cyc_m2s !== 1'b0) begin
         n_fail++;
         $display("FAIL read_release: cyc=%b want 0", cyc_m2s);
      end
      step();
      step();
   endtask

   task automatic test_refill();
      step();
      m0_cyc = 1'b1;
      m0_adr = 32'h200;
      grant_q.push_back(32'h200);
      settle();
      step();
      m1_cyc = 1'b1;
      m1_we  = 1'b1;
      m1_adr = 32'h300;
      m1_wd  = 32'h5A5A5A5A;
      grant_q.push_back(32'h300);
      settle();
      pop_grant("refill_grant_m0");
      for (int b = 0; b < 4; b++) begin
         step();
         ack_mem = 1'b1;
         dat_mem = 32'hC0DE0000 + b;
         m0_adr  = 32'h200 + 4 * b;
         rdat_q.push_back(32'hC0DE0000 + b);
         settle();
         n_chk++;
         if (m0_ack !== 1'b1 || m1_ack !== 1'b0 ||
             adr_m2s !== 32'h200 + 4 * b) begin
            n_fail++;
            $display("FAIL refill_beat%0d: ack0=%b ack1=%b adr=%h want 1 0 %h",
                     b, m0_ack, m1_ack, adr_m2s, 32'h200 + 4 * b);
         end
         pop_rdat("refill_data", m0_rd);
      end
      step();
      ack_mem = 1'b0;
      m0_cyc  = 1'b0;
      settle();
      n_chk++;
      if (cyc_m2s !== 1'b0 || m1_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL refill_drop: cyc=%b ack1=%b want 0 0", cyc_m2s, m1_ack);
      end
      step();
      settle();
      n_chk++;
      if (cyc_m2s !== 1'b0) begin
         n_fail++;
         $display("FAIL refill_dead: cyc=%b want 0", cyc_m2s);
      end
      step();
      settle();
      pop_grant("refill_grant_m1");
      n_chk++;
      if (we_m2s !== 1'b1 || dat_m2s !== 32'h5A5A5A5A) begin
         n_fail++;
         $display("FAIL refill_m1_mux: we=%b dat=%h want 1 5a5a5a5a",
                  we_m2s, dat_m2s);
      end
      step();
      m1_cyc = 1'b0;
      m1_we  = 1'b0;
      step();
      step();
   endtask

   task automatic test_back_to_back();
      logic own;
      step();
      m0_adr = 32'hA0;
      m1_adr = 32'hB0;
      m0_cyc = 1'b1;
      m1_cyc = 1'b1;
      for (int r = 0; r < 4; r++) begin
         grant_q.push_back((r % 2 == 0) ? 32'hA0 : 32'hB0);
      end
      settle();
      for (int r = 0; r < 4; r++) begin
         own = (r % 2 == 1);
         step();
         ack_mem = 1'b1;
         dat_mem = 32'h1000 + r;
         rdat_q.push_back(32'h1000 + r);
         settle();
         pop_grant("tie_grant");
         n_chk++;
         if ({m1_ack, m0_ack} !== (own ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL tie_ack_r%0d: acks=%b%b want owner m%0d",
                     r, m1_ack, m0_ack, own);
         end
         pop_rdat("tie_data", own ? m1_rd : m0_rd);
         step();
         ack_mem = 1'b0;
         if (own) m1_cyc = 1'b0;
         else m0_cyc = 1'b0;
         settle();
         n_chk++;
         if (cyc_m2s !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_drop_r%0d: cyc=%b want 0", r, cyc_m2s);
         end
         step();
         if (r == 3) begin
            m0_cyc = 1'b0;
            m1_cyc = 1'b0;
         end else if (own) begin
            m1_cyc = 1'b1;
         end else begin
            m0_cyc = 1'b1;
         end
         settle();
         n_chk++;
         if (cyc_m2s !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_idle_r%0d: cyc=%b want 0", r, cyc_m2s);
         end
      end
      step();
      step();
   endtask

   task automatic test_timeout();
      step();
      m1_cyc = 1'b1;
      m1_adr = 32'h500;
      grant_q.push_back(32'h500);
      settle();
      for (int i = 0; i < TO; i++) begin
         step();
         if (i == 2) begin
            m0_cyc = 1'b1;
            m0_adr = 32'h600;
            grant_q.push_back(32'h600);
         end
         settle();
         if (i == 0) pop_grant("to_grant_m1");
         n_chk++;
         if (cyc_m2s !== 1'b1 || m1_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_wait_%0d: cyc=%b err=%b want 1 0",
                     i, cyc_m2s, m1_err);
         end
      end
      step();
      settle();
      n_chk++;
      if (m1_err !== 1'b1 || m0_err !== 1'b0 || cyc_m2s !== 1'b0) begin
         n_fail++;
         $display("FAIL to_abort: err1=%b err0=%b cyc=%b want 1 0 0",
                  m1_err, m0_err, cyc_m2s);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 2) m1_cyc = 1'b0;
         settle();
         n_chk++;
         if (cyc_m2s !== 1'b0 || m1_err !== 1'b0 || m0_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_drain_%0d: cyc=%b errs=%b%b want 0",
                     i, cyc_m2s, m1_err, m0_err);
         end
      end
      step();
      settle();
      n_chk++;
      if (cyc_m2s !== 1'b0) begin
         n_fail++;
         $display("FAIL to_idle: cyc=%b want 0", cyc_m2s);
      end
      step();
      settle();
      pop_grant("to_grant_m0");
      step();
      m0_cyc = 1'b0;
      step();
      step();
   endtask

   task automatic test_ack_threshold();
      step();
      m0_cyc = 1'b1;
      m0_adr = 32'h700;
      grant_q.push_back(32'h700);
      settle();
      for (int i = 0; i < 2 * TO; i++) begin
         step();
         ack_mem = (i == TO - 1);
         if (i == TO - 1) begin
            dat_mem = 32'hABCD0007;
            rdat_q.push_back(32'hABCD0007);
         end
         settle();
         if (i == 0) pop_grant("thr_grant");
         n_chk++;
         if (cyc_m2s !== 1'b1 || m0_err !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_hold_%0d: cyc=%b err=%b want 1 0",
                     i, cyc_m2s, m0_err);
         end
         if (i == TO - 1) begin
            n_chk++;
            if (m0_ack !== 1'b1) begin
               n_fail++;
               $display("FAIL thr_ack: got %b want 1", m0_ack);
            end
            pop_rdat("thr_data", m0_rd);
         end
      end
      step();
      ack_mem = 1'b0;
      settle();
      n_chk++;
      if (m0_err !== 1'b1 || cyc_m2s !== 1'b0) begin
         n_fail++;
         $display("FAIL thr_late_abort: err=%b cyc=%b want 1 0",
                  m0_err, cyc_m2s);
      end
      step();
      m0_cyc = 1'b0;
      step();
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_read();
      test_refill();
      test_back_to_back();
      test_timeout();
      test_ack_threshold();
      n_chk++;
      if (grant_q.size() != 0 || rdat_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_left: grants=%0d reads=%0d want 0 0",
                  grant_q.size(), rdat_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single memory-side bus (`cyc_m2s`/`we_m2s`/`adr_m2s`/`dat_m2s`, `ack_mem`/`dat_mem`) between the cache controller (master 0) and a second requester such as the MSHR writeback drain or an instruction-side controller (master 1). It grants the bus round-robin, holds the grant for the whole `cyc` period so multi-beat line refills and writebacks stay atomic, and aborts a hung transaction with an error after a programmable number of ack-less cycles. It sits between the cache controllers and the memory model or controller.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 255, maximum consecutive granted cycles without `ack_mem` before abort; 0 disables the watchdog.

- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_cyc_i`, `m1_cyc_i`  in  1  bus request; held for the whole transaction, including all beats.
- `m0_we_i`, `m1_we_i`  in  1  write enable.
- `m0_adr_i`, `m1_adr_i`  in  ADDR_W  address.
- `m0_dat_i`, `m1_dat_i`  in  DATA_W  write data.
- `m0_dat_o`, `m1_dat_o`  out  DATA_W  read data.
- `m0_ack_o`, `m1_ack_o`  out  1  beat acknowledge.
- `m0_err_o`, `m1_err_o`  out  1  timeout abort pulse.
- `cyc_m2s`  out  1  memory cycle strobe.
- `we_m2s`  out  1  memory write enable.
- `adr_m2s`  out  ADDR_W  memory address.
- `dat_m2s`  out  DATA_W  memory write data.
- `ack_mem`  in  1  memory acknowledge.
- `dat_mem`  in  DATA_W  memory read data.

## Operation
- States:
  - IDLE: no owner; all memory-side outputs are 0.
  - GRANT: one master owns the bus.
  - ABORT: one cycle; the owner's `err` is 1.
  - DRAIN: waits for the owner to drop `cyc`.
- Registers: `state`, `owner` (1 bit), `last` (1 bit, id of the previous owner), timeout counter.
- IDLE arbitration:
  - Only one `cyc` high: that master becomes owner.
  - Both high: owner is the master whose id is not `last`.
  - On either grant: next state GRANT, `last` <= owner, counter cleared.
- GRANT mux: `cyc_m2s`/`we_m2s`/`adr_m2s`/`dat_m2s` are driven combinationally from the owner's inputs, ANDed with (state == GRANT).
- GRANT return path:
  - `ack_mem` goes to the owner's `ack_o` only.
  - `dat_mem` goes to the owner's `dat_o` only.
  - The non-owner sees `ack`/`err`/`dat` = 0.
- GRANT exit, owner `cyc` low:
  - `cyc_m2s` drops in the same cycle.
  - Next state IDLE.
  - An `ack_mem` arriving in that cycle is ignored.
- GRANT counter:
  - `ack_mem` high: counter cleared.
  - Otherwise the counter increments.
  - Counter == TIMEOUT−1 with no ack (and TIMEOUT ≠ 0): next state ABORT.
- ABORT:
  - Memory outputs are 0.
  - Owner `err_o` = 1 for exactly one cycle.
  - Next state DRAIN.
- DRAIN:
  - Memory outputs are 0.
  - Stays until the owner's `cyc` is low, then IDLE.
  - The other master's requests wait.
- Counter width is `$clog2(TIMEOUT+1)`. The counter saturates and never wraps.
- Reset, including mid-transaction: state IDLE, `last` = 1 (so master 0 wins the first tie), counter 0. No `err` is issued.

## Timing
- Reset values: every output is 0 in the cycle after the `rst` edge and stays 0 while `rst` is high.
- Grant latency: `cyc` rising in cycle N (bus IDLE) → `cyc_m2s` = 1 in cycle N+1.
- Ack path: zero latency; `ack_mem` in cycle K → owner `ack_o` in cycle K.
- Re-arbitration: owner drops `cyc` in cycle K → cycle K+1 is IDLE (dead bus cycle) → the next owner drives the bus in cycle K+2.
- Back-to-back ties alternate owners strictly.
- Abort timing: with no ack since the grant at cycle G, ABORT is at G+TIMEOUT and `err` pulses in that cycle.
- Simultaneous `ack_mem` and timeout threshold: the ack wins, the counter clears, and there is no abort.
- Requests arriving during GRANT, ABORT or DRAIN are not latched; they are seen once the state returns to IDLE.

## Structure
- Package `mem_bus_pkg`:
  - State enum `mb_state_t` (IDLE, GRANT, ABORT, DRAIN).
  - Master id localparams `MB_M0`, `MB_M1`.
  - Default widths.
- Sub-module `mem_bus_watchdog`:
  - Inputs: `clk`, `rst`, `run`, `kick` (= `ack_mem`).
  - Output: one-cycle `expired`.
  - Parameter: `TIMEOUT`.
  - The arbiter FSM, round-robin and muxing stay in the top module.

## Test plan
- Reset mid-transaction: assert `rst` during GRANT with m0 beating → next cycle all outputs are 0 and `err` never rises; release reset with both requesting → m0 granted.
- Single read: m0 `cyc`=1, `we`=0, `adr`=0x40 at N; `ack_mem`=1 with `dat_mem`=0xDEADBEEF at N+2 → `cyc_m2s`=1 and `adr_m2s`=0x40 from N+1; `m0_ack_o`=1 and `m0_dat_o`=0xDEADBEEF at N+2; m1 outputs stay 0.
- 4-beat refill with m1 contending: m0 holds `cyc` through 4 acks while m1 requests throughout → m1 gets no bus until m0 drops; one dead cycle; then m1 `cyc_m2s` with m1's address.
- Tie alternation: both request continuously with 1-beat transactions → grants m0, m1, m0, m1, each separated by one IDLE cycle.
- Timeout: TIMEOUT=8, m1 granted at G, no ack → `m1_err_o`=1 only at G+8; `cyc_m2s`=0 from G+8; stays in DRAIN until m1 drops `cyc`; m0 then granted.
- Ack at the threshold: TIMEOUT=8, `ack_mem` exactly at G+7 → no `err`; the transaction continues with the counter cleared.
